// File: rtl/vdp_sprite_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : vdp_sprite_engine                                          |
// | Description : TMS9918-style sprite engine. A self-timed line scanner     |
// |               walks the attribute table during hblank, keeps the first   |
// |               MAX_PER_LINE sprites on the next line, and fetches their    |
// |               attributes and pattern rows into a shadow list. That list  |
// |               is swapped into the active list, which the per-pixel        |
// |               renderer uses for colour, collision and overflow status.    |
// | Ports       : clk, reset            pixel clock, sync active-high reset  |
// |               i_line_start/i_next_y start a scan for line next_y         |
// |               i_attr_base/i_pattern_base   table base addresses          |
// |               i_sprite_large/i_sprite_enlarged  16x16 / pixel doubling   |
// |               o_vram_addr/o_vram_rd/i_vram_data  VRAM read port (1 wait) |
// |               i_pix_valid/i_pix_x   current pixel                        |
// |               o_pix_hit/o_pix_color registered sprite pixel              |
// |               i_status_rd           clears sticky flags                  |
// |               o_collision/o_overflow/o_overflow_num/o_busy  status       |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module vdp_sprite_engine #(
  parameter int MAX_PER_LINE = 4,
  parameter int NUM_ATTR     = 32,
  parameter int ADDR_W       = 14,
  parameter int TERM_Y       = 208
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_line_start,
  input  logic [7:0]        i_next_y,
  input  logic [ADDR_W-1:0] i_attr_base,
  input  logic [ADDR_W-1:0] i_pattern_base,
  input  logic              i_sprite_large,
  input  logic              i_sprite_enlarged,
  output logic [ADDR_W-1:0] o_vram_addr,
  output logic              o_vram_rd,
  input  logic [7:0]        i_vram_data,
  input  logic              i_pix_valid,
  input  logic [7:0]        i_pix_x,
  output logic              o_pix_hit,
  output logic [3:0]        o_pix_color,
  input  logic              i_status_rd,
  output logic              o_collision,
  output logic              o_overflow,
  output logic [4:0]        o_overflow_num,
  output logic              o_busy
);

  localparam int CNT_W = $clog2(MAX_PER_LINE + 1);
  localparam int IDX_W = (MAX_PER_LINE > 1) ? $clog2(MAX_PER_LINE) : 1;
  localparam logic [7:0]       c_TERM_Y  = 8'(TERM_Y);
  localparam logic [4:0]       c_LAST_K  = 5'(NUM_ATTR - 1);
  localparam logic [CNT_W-1:0] c_ONE_CNT = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_MAX_CNT = CNT_W'(MAX_PER_LINE);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_SCAN_Y     = 3'd1,
    S_FETCH_ATTR = 3'd2,
    S_FETCH_PAT  = 3'd3,
    S_SWAP       = 3'd4
  } state_t;

  state_t r_state, w_state_nxt;

  // r_phase 0: address/strobe cycle, 1: data-capture cycle.
  logic             r_phase;
  logic [4:0]       r_k;
  logic [7:0]       r_y;
  logic [CNT_W-1:0] r_scnt;
  logic [CNT_W-1:0] r_j;
  logic [1:0]       r_sub;
  logic             r_busy;

  logic [4:0]  r_sh_idx  [MAX_PER_LINE];
  logic [3:0]  r_sh_row  [MAX_PER_LINE];
  logic [7:0]  r_sh_x    [MAX_PER_LINE];
  logic [7:0]  r_sh_pat  [MAX_PER_LINE];
  logic        r_sh_ec   [MAX_PER_LINE];
  logic [3:0]  r_sh_col  [MAX_PER_LINE];
  logic [15:0] r_sh_bits [MAX_PER_LINE];

  logic [CNT_W-1:0] r_act_cnt;
  logic [7:0]  r_act_x    [MAX_PER_LINE];
  logic        r_act_ec   [MAX_PER_LINE];
  logic [3:0]  r_act_col  [MAX_PER_LINE];
  logic [15:0] r_act_bits [MAX_PER_LINE];

  logic r_pix_hit, r_collision, r_overflow;
  logic [3:0] r_pix_color;
  logic [4:0] r_overflow_num;

  // ---------------- scan decode ----------------
  logic [7:0] w_size, w_row;
  logic w_term, w_row_hit, w_full, w_store, w_ovf, w_scan_done;
  logic w_scan_evt, w_last_j, w_pat_last;
  logic [IDX_W-1:0] w_j_idx, w_s_idx;

  assign w_size      = i_sprite_large ? (i_sprite_enlarged ? 8'd32 : 8'd16)
                                      : (i_sprite_enlarged ? 8'd16 : 8'd8);
  assign w_row       = r_y - i_vram_data - 8'd1;
  assign w_term      = (i_vram_data == c_TERM_Y);
  assign w_row_hit   = (w_row < w_size);
  assign w_full      = (r_scnt == c_MAX_CNT);
  assign w_store     = !w_term && w_row_hit && !w_full;
  assign w_ovf       = !w_term && w_row_hit && w_full;
  assign w_scan_done = w_term || w_ovf || (r_k == c_LAST_K);
  // A scan step that is not being aborted by a fresh line_start.
  assign w_scan_evt  = (r_state == S_SCAN_Y) && r_phase && !i_line_start;
  assign w_last_j    = ((r_j + c_ONE_CNT) == r_scnt);
  assign w_pat_last  = !i_sprite_large || r_sub[0];
  assign w_j_idx     = r_j[IDX_W-1:0];
  assign w_s_idx     = r_scnt[IDX_W-1:0];

  // ---------------- address generation ----------------
  logic [6:0]  w_off_attr;
  logic [10:0] w_off_pat;
  assign w_off_attr = {r_sh_idx[w_j_idx], 2'b00} + {5'b0, r_sub} + 7'd1;
  // Large patterns: quadrant-aligned name, left column then +16 for right.
  assign w_off_pat  = i_sprite_large
                    ? {r_sh_pat[w_j_idx][7:2], r_sub[0], r_sh_row[w_j_idx]}
                    : {r_sh_pat[w_j_idx], r_sh_row[w_j_idx][2:0]};

  // ---------------- FSM next state / VRAM port ----------------
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_vram_rd   = 1'b0;
    o_vram_addr = '0;
    case (r_state)
      S_SCAN_Y: begin
        o_vram_rd   = ~r_phase;
        o_vram_addr = i_attr_base + ADDR_W'({r_k, 2'b00});
        if (r_phase && w_scan_done)
          w_state_nxt = ((r_scnt != '0) || w_store) ? S_FETCH_ATTR : S_SWAP;
      end
      S_FETCH_ATTR: begin
        o_vram_rd   = ~r_phase;
        o_vram_addr = i_attr_base + ADDR_W'(w_off_attr);
        if (r_phase && (r_sub == 2'd2) && w_last_j) w_state_nxt = S_FETCH_PAT;
      end
      S_FETCH_PAT: begin
        o_vram_rd   = ~r_phase;
        o_vram_addr = i_pattern_base + ADDR_W'(w_off_pat);
        if (r_phase && w_pat_last && w_last_j) w_state_nxt = S_SWAP;
      end
      S_SWAP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    // A new line request always restarts the scan; the shadow list is dropped.
    if (i_line_start) w_state_nxt = S_SCAN_Y;
  end

  // ---------------- scanner / fetch datapath ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase   <= 1'b0;
      r_k       <= '0;
      r_y       <= '0;
      r_scnt    <= '0;
      r_j       <= '0;
      r_sub     <= '0;
      r_busy    <= 1'b0;
      r_act_cnt <= '0;
      for (int i = 0; i < MAX_PER_LINE; i++) begin
        r_sh_idx[i]   <= '0;
        r_sh_row[i]   <= '0;
        r_sh_x[i]     <= '0;
        r_sh_pat[i]   <= '0;
        r_sh_ec[i]    <= 1'b0;
        r_sh_col[i]   <= '0;
        r_sh_bits[i]  <= '0;
        r_act_x[i]    <= '0;
        r_act_ec[i]   <= 1'b0;
        r_act_col[i]  <= '0;
        r_act_bits[i] <= '0;
      end
    end else if (i_line_start) begin
      r_y     <= i_next_y;
      r_k     <= '0;
      r_scnt  <= '0;
      r_j     <= '0;
      r_sub   <= '0;
      r_phase <= 1'b0;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        S_SCAN_Y: begin
          r_phase <= ~r_phase;
          if (r_phase) begin
            if (w_store) begin
              r_sh_idx[w_s_idx] <= r_k;
              r_sh_row[w_s_idx] <= i_sprite_enlarged ? w_row[4:1] : w_row[3:0];
              r_scnt            <= r_scnt + c_ONE_CNT;
            end
            if (!w_scan_done) r_k <= r_k + 5'd1;
            r_j   <= '0;
            r_sub <= '0;
          end
        end
        S_FETCH_ATTR: begin
          r_phase <= ~r_phase;
          if (r_phase) begin
            case (r_sub)
              2'd0:    r_sh_x[w_j_idx]   <= i_vram_data;
              2'd1:    r_sh_pat[w_j_idx] <= i_vram_data;
              default: begin
                r_sh_ec[w_j_idx]  <= i_vram_data[7];
                r_sh_col[w_j_idx] <= i_vram_data[3:0];
              end
            endcase
            if (r_sub == 2'd2) begin
              r_sub <= '0;
              r_j   <= w_last_j ? '0 : r_j + c_ONE_CNT;
            end else begin
              r_sub <= r_sub + 2'd1;
            end
          end
        end
        S_FETCH_PAT: begin
          r_phase <= ~r_phase;
          if (r_phase) begin
            // Small sprites have no right byte, so it is cleared here.
            if (!r_sub[0]) r_sh_bits[w_j_idx] <= {i_vram_data, 8'h00};
            else           r_sh_bits[w_j_idx][7:0] <= i_vram_data;
            if (w_pat_last) begin
              r_sub <= '0;
              r_j   <= r_j + c_ONE_CNT;
            end else begin
              r_sub <= 2'd1;
            end
          end
        end
        S_SWAP: begin
          r_act_cnt <= r_scnt;
          r_busy    <= 1'b0;
          for (int i = 0; i < MAX_PER_LINE; i++) begin
            r_act_x[i]    <= r_sh_x[i];
            r_act_ec[i]   <= r_sh_ec[i];
            r_act_col[i]  <= r_sh_col[i];
            r_act_bits[i] <= r_sh_bits[i];
          end
        end
        default: r_phase <= 1'b0;
      endcase
    end
  end

  // ---------------- renderer ----------------
  logic [MAX_PER_LINE-1:0] w_bit;

  for (genvar gi = 0; gi < MAX_PER_LINE; gi++) begin : g_render
    logic [8:0] w_xe;
    logic [9:0] w_dx;
    logic [3:0] w_col;
    logic       w_in;
    // Early-clock shifts the sprite 32 pixels left; 10-bit math keeps
    // negative offsets from wrapping into the visible range.
    assign w_xe  = {1'b0, r_act_x[gi]} - (r_act_ec[gi] ? 9'd32 : 9'd0);
    assign w_dx  = {2'b00, i_pix_x} - {w_xe[8], w_xe};
    assign w_in  = !w_dx[9] && (w_dx < {2'b00, w_size});
    assign w_col = i_sprite_enlarged ? w_dx[4:1] : w_dx[3:0];
    assign w_bit[gi] = (CNT_W'(gi) < r_act_cnt) && w_in
                       && r_act_bits[gi][4'd15 - w_col];
  end

  logic       w_hit, w_seen, w_coll;
  logic [3:0] w_color;

  always_comb begin
    w_hit   = 1'b0;
    w_color = 4'd0;
    w_seen  = 1'b0;
    w_coll  = 1'b0;
    for (int i = 0; i < MAX_PER_LINE; i++) begin
      if (w_bit[i]) begin
        if (w_seen) w_coll = 1'b1;
        w_seen = 1'b1;
        // Colour 0 is transparent: it collides but never masks lower sprites.
        if (!w_hit && (r_act_col[i] != 4'd0)) begin
          w_hit   = 1'b1;
          w_color = r_act_col[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pix_hit      <= 1'b0;
      r_pix_color    <= '0;
      r_collision    <= 1'b0;
      r_overflow     <= 1'b0;
      r_overflow_num <= '0;
    end else begin
      r_pix_hit   <= i_pix_valid && w_hit;
      r_pix_color <= i_pix_valid ? w_color : 4'd0;
      // Set events take priority over a status read in the same cycle.
      if (i_pix_valid && w_coll) r_collision <= 1'b1;
      else if (i_status_rd)      r_collision <= 1'b0;
      if (w_scan_evt && w_ovf)   r_overflow  <= 1'b1;
      else if (i_status_rd)      r_overflow  <= 1'b0;
      if (w_scan_evt && w_scan_done) r_overflow_num <= r_k;
    end
  end

  assign o_pix_hit      = r_pix_hit;
  assign o_pix_color    = r_pix_color;
  assign o_collision    = r_collision;
  assign o_overflow     = r_overflow;
  assign o_overflow_num = r_overflow_num;
  assign o_busy         = r_busy;

endmodule
`default_nettype wire
